// File: rtl/cartoon_pkg.sv
// Shared types and constants for the cartoonifier smoothing datapath.
package cartoon_pkg;

  localparam int TAPS       = 9;
  localparam int CENTRE_TAP = 4;

  typedef enum logic [1:0] {
    FM_NEIGH   = 2'd0,
    FM_CWEIGHT = 2'd1,
    FM_PASS    = 2'd2,
    FM_RSVD    = 2'd3
  } filt_mode_t;

endpackage

// File: rtl/window_channel_sum.sv
// Full-precision tap sum for one colour channel of a 3x3 window.
module window_channel_sum
  import cartoon_pkg::*;
#(
  parameter int CH_W = 8
) (
  input  logic [TAPS*CH_W-1:0] taps,
  input  filt_mode_t           mode,
  output logic [CH_W+3:0]      sum
);

  logic [CH_W+3:0] neigh_sum;
  logic [CH_W-1:0] centre;

  assign centre = taps[(TAPS-1-CENTRE_TAP)*CH_W +: CH_W];

  always_comb begin
    neigh_sum = '0;
    for (int t = 0; t < TAPS; t++) begin
      if (t != CENTRE_TAP) begin
        neigh_sum = neigh_sum + {4'b0000, taps[(TAPS-1-t)*CH_W +: CH_W]};
      end
    end
  end

  // Centre-weighted: centre counts as many times as all neighbours together.
  always_comb begin
    sum = neigh_sum;
    if (mode == FM_CWEIGHT) begin
      sum = neigh_sum + {1'b0, centre, 3'b000};
    end
  end

endmodule

// File: rtl/window_mean_filter.sv
// 3x3 per-channel mean filter with edge blanking and optional temporal blend
// against the previous output; two-stage pipeline with valid/ready handshake.
module window_mean_filter
  import cartoon_pkg::*;
#(
  parameter int CH_W  = 8,
  parameter int N_CH  = 3,
  parameter int PIX_W = N_CH * CH_W
) (
  input  logic                  clk,
  input  logic                  n_rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [TAPS*PIX_W-1:0] in_window,
  input  logic                  in_edge,
  input  logic                  in_sof,
  input  logic [1:0]            mode,
  input  logic                  blend_en,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [PIX_W-1:0]      out_pixel,
  output logic                  out_sof
);

  localparam int SUM_W = CH_W + 4;

  function automatic logic [CH_W-1:0] norm_ch(input logic [SUM_W-1:0] sum,
                                              input logic [CH_W-1:0]  centre,
                                              input filt_mode_t       m);
    logic [SUM_W-1:0] shifted;
    case (m)
      FM_CWEIGHT: shifted = sum >> 4;
      FM_PASS:    shifted = {4'b0000, centre};
      default:    shifted = sum >> 3;
    endcase
    return shifted[CH_W-1:0];
  endfunction

  function automatic logic [CH_W-1:0] blend_ch(input logic [CH_W-1:0] a,
                                               input logic [CH_W-1:0] b);
    logic [CH_W:0] s;
    s = {1'b0, a} + {1'b0, b};
    s = s >> 1;
    return s[CH_W-1:0];
  endfunction

  logic                  advance;
  filt_mode_t            in_mode;
  logic [SUM_W-1:0]      ch_sum [N_CH];

  logic [SUM_W-1:0]      sum_p1_q [N_CH];
  logic [SUM_W-1:0]      sum_p1_d [N_CH];
  logic [PIX_W-1:0]      centre_p1_q, centre_p1_d;
  logic                  edge_p1_q, edge_p1_d;
  logic                  sof_p1_q, sof_p1_d;
  filt_mode_t            mode_p1_q, mode_p1_d;
  logic                  blend_p1_q, blend_p1_d;
  logic                  vld_p1_q, vld_p1_d;

  logic [PIX_W-1:0]      res_pixel;
  logic                  use_blend;
  logic [PIX_W-1:0]      out_pixel_q, out_pixel_d;
  logic                  out_sof_q, out_sof_d;
  logic                  vld_p2_q, vld_p2_d;
  logic [PIX_W-1:0]      hist_q, hist_d;
  logic                  hist_vld_q, hist_vld_d;

  assign in_mode   = filt_mode_t'(mode);
  assign advance   = !vld_p2_q || out_ready;
  assign in_ready  = advance;
  assign out_valid = vld_p2_q;
  assign out_pixel = out_pixel_q;
  assign out_sof   = out_sof_q;

  for (genvar c = 0; c < N_CH; c++) begin : g_ch
    logic [TAPS*CH_W-1:0] taps_c;
    for (genvar t = 0; t < TAPS; t++) begin : g_tap
      assign taps_c[(TAPS-1-t)*CH_W +: CH_W] =
        in_window[(TAPS-1-t)*PIX_W + (N_CH-1-c)*CH_W +: CH_W];
    end
    window_channel_sum #(.CH_W(CH_W)) u_sum (
      .taps (taps_c),
      .mode (in_mode),
      .sum  (ch_sum[c])
    );
  end

  // Stage 1: capture sums and per-beat side information
  always_comb begin
    sum_p1_d    = sum_p1_q;
    centre_p1_d = centre_p1_q;
    edge_p1_d   = edge_p1_q;
    sof_p1_d    = sof_p1_q;
    mode_p1_d   = mode_p1_q;
    blend_p1_d  = blend_p1_q;
    vld_p1_d    = vld_p1_q;
    if (advance) begin
      sum_p1_d    = ch_sum;
      centre_p1_d = in_window[(TAPS-1-CENTRE_TAP)*PIX_W +: PIX_W];
      edge_p1_d   = in_edge;
      sof_p1_d    = in_sof;
      mode_p1_d   = in_mode;
      blend_p1_d  = blend_en;
      vld_p1_d    = in_valid;
    end
  end

  // Stage 2: normalise, blend with history, register the output
  always_comb begin
    use_blend = blend_p1_q && hist_vld_q && !sof_p1_q;
    res_pixel = '0;
    for (int c = 0; c < N_CH; c++) begin
      logic [CH_W-1:0] avg;
      avg = norm_ch(sum_p1_q[c], centre_p1_q[(N_CH-1-c)*CH_W +: CH_W], mode_p1_q);
      if (edge_p1_q) begin
        res_pixel[(N_CH-1-c)*CH_W +: CH_W] = '0;
      end else if (use_blend) begin
        res_pixel[(N_CH-1-c)*CH_W +: CH_W] =
          blend_ch(hist_q[(N_CH-1-c)*CH_W +: CH_W], avg);
      end else begin
        res_pixel[(N_CH-1-c)*CH_W +: CH_W] = avg;
      end
    end
  end

  always_comb begin
    vld_p2_d    = vld_p2_q;
    out_pixel_d = out_pixel_q;
    out_sof_d   = out_sof_q;
    hist_d      = hist_q;
    hist_vld_d  = hist_vld_q;
    if (advance) begin
      vld_p2_d = vld_p1_q;
      if (vld_p1_q) begin
        out_pixel_d = res_pixel;
        out_sof_d   = sof_p1_q;
        if (edge_p1_q) begin
          hist_vld_d = 1'b0;
        end else begin
          hist_d     = res_pixel;
          hist_vld_d = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!n_rst) begin
      vld_p1_q    <= 1'b0;
      vld_p2_q    <= 1'b0;
      out_pixel_q <= '0;
      out_sof_q   <= 1'b0;
      hist_q      <= '0;
      hist_vld_q  <= 1'b0;
    end else begin
      vld_p1_q    <= vld_p1_d;
      vld_p2_q    <= vld_p2_d;
      out_pixel_q <= out_pixel_d;
      out_sof_q   <= out_sof_d;
      hist_q      <= hist_d;
      hist_vld_q  <= hist_vld_d;
    end
  end

  always_ff @(posedge clk) begin
    sum_p1_q    <= sum_p1_d;
    centre_p1_q <= centre_p1_d;
    edge_p1_q   <= edge_p1_d;
    sof_p1_q    <= sof_p1_d;
    mode_p1_q   <= mode_p1_d;
    blend_p1_q  <= blend_p1_d;
  end

endmodule

// File: tb/tb_window_mean_filter.sv
// Bench for window_mean_filter: vector table, scoreboard and handshake corner cases.
module tb_window_mean_filter;
  import cartoon_pkg::*;

  localparam int CH_W  = 8;
  localparam int N_CH  = 3;
  localparam int PIX_W = 24;
  localparam int WIN_W = 9 * PIX_W;

  logic             clk = 1'b0;
  logic             n_rst = 1'b0;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [WIN_W-1:0] in_window = '0;
  logic             in_edge = 1'b0;
  logic             in_sof = 1'b0;
  logic [1:0]       mode = 2'd0;
  logic             blend_en = 1'b0;
  logic             out_valid;
  logic             out_ready = 1'b1;
  logic [PIX_W-1:0] out_pixel;
  logic             out_sof;

  window_mean_filter #(.CH_W(CH_W), .N_CH(N_CH)) dut (
    .clk       (clk),
    .n_rst     (n_rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_window (in_window),
    .in_edge   (in_edge),
    .in_sof    (in_sof),
    .mode      (mode),
    .blend_en  (blend_en),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_pixel (out_pixel),
    .out_sof   (out_sof)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [WIN_W-1:0] win;
    logic             edg;
    logic             sof;
    logic [1:0]       md;
    logic             bl;
    logic [PIX_W-1:0] exp;
  } vec_t;

  vec_t         vecs [9];
  logic [PIX_W:0] sb [$];
  logic [PIX_W:0] cur_exp = '0;
  int           n_cmp = 0;
  int           n_bad = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %h required %h (t=%0t)", name, act, req, $time);
    end
  endtask

  function automatic logic [WIN_W-1:0] mk_win(input logic [PIX_W-1:0] nb,
                                             input logic [PIX_W-1:0] ctr);
    logic [WIN_W-1:0] w;
    for (int t = 0; t < 9; t++) w[(8-t)*PIX_W +: PIX_W] = (t == 4) ? ctr : nb;
    return w;
  endfunction

  // Independent arithmetic reference for non-blended beats.
  function automatic logic [PIX_W-1:0] model(input logic [WIN_W-1:0] w, input logic [1:0] md);
    logic [PIX_W-1:0] r;
    r = '0;
    for (int c = 0; c < 3; c++) begin
      int nsum;
      int ctr;
      int v;
      int avg;
      nsum = 0;
      ctr  = 0;
      for (int t = 0; t < 9; t++) begin
        v = int'(w[(8-t)*PIX_W + (2-c)*8 +: 8]);
        if (t == 4) ctr = v;
        else nsum += v;
      end
      case (md)
        2'd1:    avg = (nsum + 8 * ctr) / 16;
        2'd2:    avg = ctr;
        default: avg = nsum / 8;
      endcase
      r[(2-c)*8 +: 8] = avg[7:0];
    end
    return r;
  endfunction

  task automatic drive(input logic [WIN_W-1:0] win, input logic edg, input logic sof,
                       input logic [1:0] md, input logic bl, input logic [PIX_W-1:0] exp,
                       output int acc);
    int w;
    in_window = win;
    in_edge   = edg;
    in_sof    = sof;
    mode      = md;
    blend_en  = bl;
    cur_exp   = {sof, exp};
    in_valid  = 1'b1;
    w = 0;
    @(negedge clk);
    while (!in_ready && w < 50) begin
      w++;
      @(negedge clk);
    end
    acc = cyc;
    if (!in_ready) check("drive_timeout", 32'd0, 32'd1);
    @(posedge clk);
    #1;
  endtask

  task automatic drain();
    int w;
    in_valid = 1'b0;
    w = 0;
    while (sb.size() != 0 && w < 100) begin
      @(posedge clk);
      w++;
    end
    check("drain_empty", sb.size(), 32'd0);
    @(posedge clk);
    #1;
  endtask

  initial begin
    int           acc;
    int           w;
    logic [23:0]  held;
    bit           have;
    bit           stop_tog;
    logic [WIN_W-1:0] rw;
    logic [1:0]   rmd;
    logic [WIN_W-1:0] ramp;

    fork
      forever begin
        logic [PIX_W:0] e;
        @(negedge clk);
        if (n_rst) begin
          if (in_valid && in_ready) sb.push_back(cur_exp);
          if (out_valid && out_ready) begin
            if (sb.size() == 0) begin
              n_cmp++;
              n_bad++;
              $display("FAIL sb_unexpected: got %h required no output", out_pixel);
            end else begin
              e = sb.pop_front();
              check("sb_pixel", 32'(out_pixel), 32'(e[PIX_W-1:0]));
              check("sb_sof", 32'(out_sof), 32'(e[PIX_W]));
            end
          end
        end
      end
      begin
        #500000;
        $display("FAIL watchdog: got timeout required completion");
        $fatal(1);
      end
    join_none

    for (int t = 0; t < 9; t++)
      ramp[(8-t)*PIX_W +: PIX_W] = (t == 4) ? 24'h000000 : {8'(t * 16), 8'(t), 8'(255 - t)};

    vecs[0] = '{mk_win(24'h4080C0, 24'h4080C0), 1'b0, 1'b1, 2'd0, 1'b0, 24'h4080C0};
    vecs[1] = '{mk_win(24'hFFFFFF, 24'h000000), 1'b0, 1'b0, 2'd1, 1'b0, 24'h7F7F7F};
    vecs[2] = '{mk_win(24'hFFFFFF, 24'h000000), 1'b0, 1'b1, 2'd0, 1'b0, 24'hFFFFFF};
    vecs[3] = '{mk_win(24'hFFFFFF, 24'h000000), 1'b0, 1'b0, 2'd2, 1'b0, 24'h000000};
    vecs[4] = '{mk_win(24'hFFFFFF, 24'h000000), 1'b0, 1'b1, 2'd3, 1'b0, 24'hFFFFFF};
    vecs[5] = '{mk_win(24'h4080C0, 24'h4080C0), 1'b1, 1'b0, 2'd0, 1'b0, 24'h000000};
    vecs[6] = '{ramp, 1'b0, 1'b0, 2'd0, 1'b0, 24'h4004FB};
    vecs[7] = '{ramp, 1'b0, 1'b1, 2'd1, 1'b0, 24'h20027D};
    vecs[8] = '{ramp, 1'b0, 1'b0, 2'd2, 1'b0, 24'h000000};

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    n_rst = 1'b1;
    @(negedge clk);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_out_pixel", 32'(out_pixel), 32'd0);
    check("rst_out_sof", 32'(out_sof), 32'd0);
    check("rst_in_ready", 32'(in_ready), 32'd1);
    @(posedge clk);
    #1;

    // Latency of a single flat beat
    drive(mk_win(24'h4080C0, 24'h4080C0), 1'b0, 1'b1, 2'd0, 1'b0, 24'h4080C0, acc);
    in_valid = 1'b0;
    w = 0;
    @(negedge clk);
    while (!out_valid && w < 10) begin
      w++;
      @(negedge clk);
    end
    check("latency", 32'(cyc - acc), 32'd2);
    drain();

    // Table, back to back
    for (int i = 0; i < 9; i++)
      drive(vecs[i].win, vecs[i].edg, vecs[i].sof, vecs[i].md, vecs[i].bl, vecs[i].exp, acc);
    drain();

    // Random windows under random back-pressure
    stop_tog = 1'b0;
    fork
      begin
        for (int i = 0; i < 10; i++) begin
          for (int t = 0; t < 9; t++) rw[(8-t)*PIX_W +: PIX_W] = 24'($urandom());
          rmd = 2'($urandom_range(0, 3));
          drive(rw, 1'b0, 1'($urandom_range(0, 1)), rmd, 1'b0, model(rw, rmd), acc);
        end
        in_valid = 1'b0;
        stop_tog = 1'b1;
      end
      begin
        while (!stop_tog) begin
          @(posedge clk);
          #1;
          out_ready = 1'($urandom_range(0, 1));
        end
        out_ready = 1'b1;
      end
    join
    drain();

    // Temporal blend
    drive(mk_win(24'h204060, 24'h204060), 1'b0, 1'b1, 2'd0, 1'b1, 24'h204060, acc);
    drive(mk_win(24'h60A0E0, 24'h60A0E0), 1'b0, 1'b0, 2'd0, 1'b1, 24'h4070A0, acc);
    drain();

    // Edge mid-stream breaks the blend chain
    drive(mk_win(24'h101010, 24'h101010), 1'b0, 1'b1, 2'd0, 1'b1, 24'h101010, acc);
    drive(mk_win(24'h777777, 24'h777777), 1'b1, 1'b0, 2'd0, 1'b1, 24'h000000, acc);
    drive(mk_win(24'h303030, 24'h303030), 1'b0, 1'b0, 2'd0, 1'b1, 24'h303030, acc);
    drain();

    // Stall: out_ready low for 5 cycles with in_valid held
    have = 1'b0;
    held = '0;
    out_ready = 1'b0;
    fork
      begin
        for (int i = 0; i < 6; i++)
          drive(mk_win(24'h000000, 24'(24'h010203 * (i + 1))), 1'b0, 1'b0, 2'd2, 1'b0,
                24'(24'h010203 * (i + 1)), acc);
        in_valid = 1'b0;
      end
      begin
        repeat (5) begin
          @(negedge clk);
          if (out_valid) begin
            if (!have) begin
              held = out_pixel;
              have = 1'b1;
            end else begin
              check("stall_hold", 32'(out_pixel), 32'(held));
            end
            check("stall_in_ready", 32'(in_ready), 32'd0);
          end
        end
        check("stall_seen", 32'(have), 32'd1);
        @(posedge clk);
        #1;
        out_ready = 1'b1;
      end
    join
    drain();

    // Reset with two beats in flight
    drive(mk_win(24'h101010, 24'h101010), 1'b0, 1'b1, 2'd0, 1'b1, 24'h101010, acc);
    drain();
    drive(mk_win(24'h505050, 24'h505050), 1'b0, 1'b1, 2'd0, 1'b0, 24'h505050, acc);
    drive(mk_win(24'h505050, 24'h505050), 1'b0, 1'b1, 2'd0, 1'b0, 24'h505050, acc);
    in_valid = 1'b0;
    n_rst = 1'b0;
    @(posedge clk);
    #1;
    n_rst = 1'b1;
    sb.delete();
    @(negedge clk);
    check("rst2_out_valid", 32'(out_valid), 32'd0);
    check("rst2_out_pixel", 32'(out_pixel), 32'd0);
    check("rst2_out_sof", 32'(out_sof), 32'd0);
    check("rst2_in_ready", 32'(in_ready), 32'd1);
    @(posedge clk);
    #1;
    drive(mk_win(24'h303030, 24'h303030), 1'b0, 1'b0, 2'd0, 1'b1, 24'h303030, acc);
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
